// File: rtl/split_pipe_pkg.sv
// Shared constants and response-source encoding for the split_pipe router.
package split_pipe_pkg;

   localparam logic [31:0] DECERR_WORD = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_SLAVE,
      RSP_DECERR
   } rsp_src_e;

endpackage

// File: rtl/interconnect.vh
// Slot layout helpers shared by flattened multi-port interconnect buses.
// Slot k of a flat bus of W-bit fields occupies bits [k*W +: W].
`ifndef INTERCONNECT_VH
`define INTERCONNECT_VH

`define IC_STRB_W(dw)          ((dw)/8)
`define IC_SLOT(k, w)          ((k)*(w)) +: (w)

`define IC_VALID_SLOT(k)       (k)
`define IC_READY_SLOT(k)       (k)
`define IC_RVALID_SLOT(k)      (k)
`define IC_ADDR_SLOT(k, aw)    `IC_SLOT(k, aw)
`define IC_WDATA_SLOT(k, dw)   `IC_SLOT(k, dw)
`define IC_WSTRB_SLOT(k, dw)   `IC_SLOT(k, `IC_STRB_W(dw))
`define IC_RDATA_SLOT(k, dw)   `IC_SLOT(k, dw)

`endif

// File: rtl/split_pipe_track.sv
// Outstanding-transaction tracker: counts accepted-but-unanswered requests and
// remembers which slave they all went to.
module split_pipe_track
   import split_pipe_pkg::*;
#(
   parameter int  MAX_PEND = 4,
   parameter int  SEL_W    = 1,
   localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic             retire,
   input  logic [SEL_W-1:0] sel,
   output logic [CNT_W-1:0] pend_cnt,
   output logic [SEL_W-1:0] lock_sel,
   output logic             full
);

   assign full = (pend_cnt == CNT_W'(MAX_PEND));

   // Counter saturates at both ends; upstream stall logic keeps it there anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_cnt <= '0;
         lock_sel <= '0;
      end else begin
         if (accept && pend_cnt == '0)
            lock_sel <= sel;
         if (accept && !retire && !full)
            pend_cnt <= pend_cnt + 1'b1;
         else if (retire && !accept && pend_cnt != '0)
            pend_cnt <= pend_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/split_pipe.sv
// split_pipe: one master routed to N_SLAVES slaves; locked to one slave while any request is outstanding.
// Optional: define SPLIT_PIPE_DECERR_EN to answer out-of-range s_sel with a DEADBEEF decode-error beat.
`include "interconnect.vh"

module split_pipe
   import split_pipe_pkg::*;
#(
   parameter int  N_SLAVES = 2,
   parameter int  ADDR_W   = 32,
   parameter int  DATA_W   = 32,
   parameter int  MAX_PEND = 4,
   localparam int SEL_W    = $clog2(N_SLAVES),
   localparam int STRB_W   = `IC_STRB_W(DATA_W),
   localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       m_valid,
   input  logic [ADDR_W-1:0]          m_addr,
   input  logic [DATA_W-1:0]          m_wdata,
   input  logic [STRB_W-1:0]          m_wstrb,
   input  logic [SEL_W-1:0]           s_sel,
   output logic                       m_ready,
   output logic                       m_rvalid,
   output logic [DATA_W-1:0]          m_rdata,
   output logic [N_SLAVES-1:0]        s_valid,
   output logic [N_SLAVES*ADDR_W-1:0] s_addr,
   output logic [N_SLAVES*DATA_W-1:0] s_wdata,
   output logic [N_SLAVES*STRB_W-1:0] s_wstrb,
   input  logic [N_SLAVES-1:0]        s_ready,
   input  logic [N_SLAVES-1:0]        s_rvalid,
   input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

   logic [CNT_W-1:0]  pend_cnt;
   logic [SEL_W-1:0]  lock_sel;
   logic              full, stall, accept, retire;
   logic              sel_ok, decerr_ok, err_rsp, slv_rsp;
   logic              rdy_sel, rvalid_lock;
   logic [DATA_W-1:0] rdata_lock;
   rsp_src_e          rsp_src;

   // Decoded muxes; an out-of-range select or lock simply matches no slot.
   always_comb begin
      sel_ok      = 1'b0;
      rdy_sel     = 1'b0;
      rvalid_lock = 1'b0;
      rdata_lock  = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (s_sel == SEL_W'(k)) begin
            sel_ok  = 1'b1;
            rdy_sel = s_ready[`IC_READY_SLOT(k)];
         end
         if (lock_sel == SEL_W'(k)) begin
            rvalid_lock = s_rvalid[`IC_RVALID_SLOT(k)];
            rdata_lock  = s_rdata[`IC_RDATA_SLOT(k, DATA_W)];
         end
      end
   end

   assign stall   = full | ((pend_cnt != '0) & (s_sel != lock_sel));
   assign m_ready = sel_ok ? (rdy_sel & ~stall) : decerr_ok;
   assign accept  = m_valid & m_ready;
   assign slv_rsp = rvalid_lock & (pend_cnt != '0);
   assign retire  = slv_rsp | err_rsp;

   for (genvar k = 0; k < N_SLAVES; k++) begin : g_slot
      assign s_valid[`IC_VALID_SLOT(k)]           = m_valid & ~stall & (s_sel == SEL_W'(k));
      assign s_addr[`IC_ADDR_SLOT(k, ADDR_W)]     = m_addr;
      assign s_wdata[`IC_WDATA_SLOT(k, DATA_W)]   = m_wdata;
      assign s_wstrb[`IC_WSTRB_SLOT(k, DATA_W)]   = (s_sel == SEL_W'(k)) ? m_wstrb : '0;
   end

`ifdef SPLIT_PIPE_DECERR_EN
   logic err_pend;

   // Decode errors are only taken on an idle pipe, so at most one is ever in flight.
   assign decerr_ok = ~sel_ok & (pend_cnt == '0);
   assign err_rsp   = err_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_pend <= 1'b0;
      else     err_pend <= accept & ~sel_ok;
   end
`else
   assign decerr_ok = 1'b0;
   assign err_rsp   = 1'b0;
`endif

   always_comb begin
      rsp_src = RSP_NONE;
      if (err_rsp)      rsp_src = RSP_DECERR;
      else if (slv_rsp) rsp_src = RSP_SLAVE;
   end

   assign m_rvalid = (rsp_src != RSP_NONE);
   assign m_rdata  = (rsp_src == RSP_DECERR) ? DATA_W'(DECERR_WORD) : rdata_lock;

   split_pipe_track #(
      .MAX_PEND (MAX_PEND),
      .SEL_W    (SEL_W)
   ) u_track (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .retire   (retire),
      .sel      (s_sel),
      .pend_cnt (pend_cnt),
      .lock_sel (lock_sel),
      .full     (full)
   );

endmodule
